// File: rtl/latch_ex_mem_skid.sv
// EX->MEM pipeline register with valid/ready handshake, stall back-pressure and flush.
// Define LATCH_EX_MEM_SKID_EN to add a skid entry that registers ex_ready.
module latch_ex_mem_skid #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic                  ex_register_write_enable,
  input  logic [ADDR_WIDTH-1:0] ex_register_write_address,
  input  logic [DATA_WIDTH-1:0] ex_register_write_data,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_register_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_register_write_address,
  output logic [DATA_WIDTH-1:0] mem_register_write_data
);

`ifdef LATCH_EX_MEM_SKID_EN
  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
`else
  typedef enum logic {EMPTY, FULL} state_t;
`endif

  state_t                state_q, state_d;
  logic                  main_we_q, main_we_d;
  logic [ADDR_WIDTH-1:0] main_addr_q, main_addr_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic                  accept, consume;

`ifdef LATCH_EX_MEM_SKID_EN
  logic                  skid_we_q, skid_we_d;
  logic [ADDR_WIDTH-1:0] skid_addr_q, skid_addr_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  ex_ready_q;

  assign ex_ready = ex_ready_q;
`else
  assign ex_ready = !mem_valid || mem_ready;
`endif

  assign mem_valid = (state_q != EMPTY);
  assign accept    = ex_valid && ex_ready;
  assign consume   = mem_valid && mem_ready;

  assign mem_register_write_enable  = main_we_q && mem_valid;
  assign mem_register_write_address = main_addr_q;
  assign mem_register_write_data    = main_data_q;

  always_comb begin
    state_d     = state_q;
    main_we_d   = main_we_q;
    main_addr_d = main_addr_q;
    main_data_d = main_data_q;
`ifdef LATCH_EX_MEM_SKID_EN
    skid_we_d   = skid_we_q;
    skid_addr_d = skid_addr_q;
    skid_data_d = skid_data_q;
`endif
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d     = FULL;
            main_we_d   = ex_register_write_enable;
            main_addr_d = ex_register_write_address;
            main_data_d = ex_register_write_data;
          end
        end
        FULL: begin
          if (accept) begin
`ifdef LATCH_EX_MEM_SKID_EN
            if (consume) begin
              main_we_d   = ex_register_write_enable;
              main_addr_d = ex_register_write_address;
              main_data_d = ex_register_write_data;
            end else begin
              // MEM is stalled: park the new beat behind the held one
              state_d     = SKID;
              skid_we_d   = ex_register_write_enable;
              skid_addr_d = ex_register_write_address;
              skid_data_d = ex_register_write_data;
            end
`else
            main_we_d   = ex_register_write_enable;
            main_addr_d = ex_register_write_address;
            main_data_d = ex_register_write_data;
`endif
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
`ifdef LATCH_EX_MEM_SKID_EN
        SKID: begin
          if (consume) begin
            state_d     = FULL;
            main_we_d   = skid_we_q;
            main_addr_d = skid_addr_q;
            main_data_d = skid_data_q;
          end
        end
`endif
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_we_q   <= 1'b0;
      main_addr_q <= '0;
      main_data_q <= '0;
`ifdef LATCH_EX_MEM_SKID_EN
      skid_we_q   <= 1'b0;
      skid_addr_q <= '0;
      skid_data_q <= '0;
      ex_ready_q  <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      main_we_q   <= main_we_d;
      main_addr_q <= main_addr_d;
      main_data_q <= main_data_d;
`ifdef LATCH_EX_MEM_SKID_EN
      skid_we_q   <= skid_we_d;
      skid_addr_q <= skid_addr_d;
      skid_data_q <= skid_data_d;
      ex_ready_q  <= (state_d != SKID);
`endif
    end
  end

endmodule

// File: tb/tb_latch_ex_mem_skid.sv
// Self-checking bench for latch_ex_mem_skid: queue-based reference model, directed and random steps.
module tb_latch_ex_mem_skid;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic        ex_we = 1'b0;
  logic [4:0]  ex_addr = '0;
  logic [31:0] ex_data = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;

  logic        w_ex_valid = 1'b0;
  logic        w_ex_ready;
  logic        w_ex_we = 1'b0;
  logic [5:0]  w_ex_addr = '0;
  logic [63:0] w_ex_data = '0;
  logic        w_mem_valid;
  logic        w_mem_ready = 1'b0;
  logic        w_mem_we;
  logic [5:0]  w_mem_addr;
  logic [63:0] w_mem_data;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } beat_t;
  beat_t q[$];

  always #5 clock = ~clock;

  latch_ex_mem_skid dut (
    .clock(clock), .reset(reset), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_register_write_enable(ex_we), .ex_register_write_address(ex_addr),
    .ex_register_write_data(ex_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_register_write_enable(mem_we), .mem_register_write_address(mem_addr),
    .mem_register_write_data(mem_data)
  );

  latch_ex_mem_skid #(.DATA_WIDTH(64), .ADDR_WIDTH(6)) dut_wide (
    .clock(clock), .reset(reset), .flush(1'b0),
    .ex_valid(w_ex_valid), .ex_ready(w_ex_ready),
    .ex_register_write_enable(w_ex_we), .ex_register_write_address(w_ex_addr),
    .ex_register_write_data(w_ex_data),
    .mem_valid(w_mem_valid), .mem_ready(w_mem_ready),
    .mem_register_write_enable(w_mem_we), .mem_register_write_address(w_mem_addr),
    .mem_register_write_data(w_mem_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_ready(input logic mr);
`ifdef LATCH_EX_MEM_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || mr;
`endif
  endfunction

  // Called just after inputs settle; compares every output against the model.
  task automatic check_outputs(input string tag);
    logic exp_valid;
    exp_valid = (q.size() > 0);
    chk({tag, ".ex_ready"}, {63'd0, ex_ready}, {63'd0, model_ready(mem_ready)});
    chk({tag, ".mem_valid"}, {63'd0, mem_valid}, {63'd0, exp_valid});
    if (exp_valid) begin
      chk({tag, ".mem_we"}, {63'd0, mem_we}, {63'd0, q[0].we});
      chk({tag, ".mem_addr"}, {59'd0, mem_addr}, {59'd0, q[0].addr});
      chk({tag, ".mem_data"}, {32'd0, mem_data}, {32'd0, q[0].data});
    end else begin
      chk({tag, ".mem_we_bubble"}, {63'd0, mem_we}, 64'd0);
    end
  endtask

  // One clock cycle: drive inputs, check, advance model at the edge. Starts and ends at negedge.
  task automatic step(input string tag, input logic ev, input logic we, input logic [4:0] a,
                      input logic [31:0] d, input logic mr, input logic fl);
    logic acc, con;
    ex_valid = ev; ex_we = we; ex_addr = a; ex_data = d; mem_ready = mr; flush = fl;
    #1;
    check_outputs(tag);
    acc = ev && model_ready(mr);
    con = (q.size() > 0) && mr;
    @(posedge clock);
    if (fl) begin
      q.delete();
    end else begin
      if (con) void'(q.pop_front());
      if (acc) q.push_back('{we: we, addr: a, data: d});
    end
    @(negedge clock);
    $display("step %-10s ev=%0d mr=%0d fl=%0d -> held=%0d", tag, ev, mr, fl, q.size());
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst.mem_valid", {63'd0, mem_valid}, 64'd0);
    chk("rst.mem_we", {63'd0, mem_we}, 64'd0);
    chk("rst.mem_addr", {59'd0, mem_addr}, 64'd0);
    chk("rst.mem_data", {32'd0, mem_data}, 64'd0);
    chk("rst.ex_ready", {63'd0, ex_ready}, 64'd1);
    chk("rst.w_mem_valid", {63'd0, w_mem_valid}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Streaming
    step("stream0", 1, 1, 5'd5, 32'h0000_0011, 1, 0);
    step("stream1", 1, 1, 5'd6, 32'h0000_0022, 1, 0);
    step("stream2", 1, 0, 5'd7, 32'hFFFF_FFFF, 1, 0);
    step("stream3", 0, 0, 5'd0, 32'h0, 1, 0);
    step("stream4", 0, 0, 5'd0, 32'h0, 1, 0);

    // Stall: present A then keep presenting B until accepted, then drain
    step("stallA", 1, 1, 5'd3, 32'hA, 0, 0);
    step("stallB", 1, 1, 5'd4, 32'hB, 0, 0);
    step("stallB2", (q.size() < 2), 1, 5'd4, 32'hB, 0, 0);
    step("stallH", (q.size() < 2), 1, 5'd4, 32'hB, 0, 0);
    step("drain0", (q.size() < 2), 1, 5'd4, 32'hB, 1, 0);
    step("drain1", 0, 0, 5'd0, 32'h0, 1, 0);
    step("drain2", 0, 0, 5'd0, 32'h0, 1, 0);
    step("drain3", 0, 0, 5'd0, 32'h0, 1, 0);

    // Flush with entries held and a new beat offered
    step("flA", 1, 1, 5'd8, 32'h8, 0, 0);
    step("flB", 1, 1, 5'd9, 32'h9, 0, 0);
    step("flush", 1, 1, 5'd10, 32'h10, 0, 1);
    step("postfl0", 0, 0, 5'd0, 32'h0, 1, 0);
    step("postfl1", 0, 0, 5'd0, 32'h0, 1, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom),
           $urandom, ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
    end
    step("settle", 0, 0, 5'd0, 32'h0, 1, 0);
    step("settle", 0, 0, 5'd0, 32'h0, 1, 0);

    // Asynchronous reset mid-cycle with a beat held
    step("preRst", 1, 1, 5'd17, 32'h1234_5678, 0, 0);
    ex_valid = 1'b0;
    #2;
    chk("preRst.mem_valid", {63'd0, mem_valid}, 64'd1);
    reset = 1'b1;
    #1;
    q.delete();
    chk("arst.mem_valid", {63'd0, mem_valid}, 64'd0);
    chk("arst.mem_we", {63'd0, mem_we}, 64'd0);
    chk("arst.mem_addr", {59'd0, mem_addr}, 64'd0);
    chk("arst.mem_data", {32'd0, mem_data}, 64'd0);
    chk("arst.ex_ready", {63'd0, ex_ready}, 64'd1);
    @(negedge clock);
    reset = 1'b0;
    step("postRst", 1, 1, 5'd2, 32'h2, 1, 0);
    step("postRst1", 0, 0, 5'd0, 32'h0, 1, 0);

    // Wide instance
    w_ex_valid = 1'b1; w_ex_we = 1'b1; w_ex_addr = 6'd63;
    w_ex_data = 64'hDEAD_BEEF_0123_4567; w_mem_ready = 1'b1;
    #1;
    chk("wide.ex_ready", {63'd0, w_ex_ready}, 64'd1);
    @(negedge clock);
    w_ex_valid = 1'b0;
    #1;
    chk("wide.mem_valid", {63'd0, w_mem_valid}, 64'd1);
    chk("wide.mem_we", {63'd0, w_mem_we}, 64'd1);
    chk("wide.mem_addr", {58'd0, w_mem_addr}, 64'd63);
    chk("wide.mem_data", w_mem_data, 64'hDEAD_BEEF_0123_4567);
    $display("wide beat addr=%0d data=%h", w_mem_addr, w_mem_data);
    @(negedge clock);
    chk("wide.drained", {63'd0, w_mem_valid}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/latch_ex_mem_skid.md
# latch_ex_mem_skid

Parametrised EX→MEM pipeline register with a valid/ready handshake, stall back-pressure and synchronous flush. It sits between the execute stage and the memory stage and carries the register-writeback triple (enable, address, data) plus a valid bit. The memory stage can therefore stall without losing or duplicating an instruction, and a branch or exception can squash the in-flight entry. An optional skid entry breaks the combinational ready path from MEM back to EX.

## Interface
- DATA_WIDTH, 32, width of the writeback data field
- ADDR_WIDTH, 5, width of the register-file address field
- clock  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous squash of all held entries
- ex_valid  in  1  EX presents a beat
- ex_ready  out  1  latch can accept a beat this cycle
- ex_register_write_enable  in  1  writeback enable
- ex_register_write_address  in  ADDR_WIDTH  destination register
- ex_register_write_data  in  DATA_WIDTH  writeback value
- mem_valid  out  1  MEM-side beat present
- mem_ready  in  1  MEM consumes the beat this cycle
- mem_register_write_enable  out  1  stored enable gated by mem_valid
- mem_register_write_address  out  ADDR_WIDTH  destination register
- mem_register_write_data  out  DATA_WIDTH  writeback value

## Operation
- Accept: ex_valid && ex_ready at a clock edge.
- Consume: mem_valid && mem_ready at a clock edge.
- Main entry drives the mem_* outputs. mem_register_write_enable = stored enable AND mem_valid, so a bubble never writes.
- State machine:
  - EMPTY
    - accept → FULL
  - FULL
    - accept and consume → FULL (main reloaded)
    - accept only → SKID (input captured in skid entry)
    - consume only → EMPTY
    - neither → FULL, outputs held
  - SKID
    - consume → FULL (skid entry moves into main)
    - otherwise hold
    - no accept is possible, because ex_ready=0
- ex_ready = 1 in EMPTY and FULL, 0 in SKID. It is a registered decode of state.
- Flush:
  - Forces EMPTY at the next edge from any state.
  - A same-cycle accept is discarded and a same-cycle consume is irrelevant; flush has priority.
  - Data fields need not clear; the valid/enable gating hides them.
- While mem_valid && !mem_ready, every mem_* output stays bit-stable until consumed or flushed.
- No beat is dropped or duplicated except by flush.

## Timing
- Reset values:
  - state EMPTY
  - mem_valid 0
  - mem_register_write_enable 0
  - mem_register_write_address 0
  - mem_register_write_data 0
  - ex_ready 1
  - skid entry 0
- Reset asserted mid-operation discards both entries immediately, without waiting for a clock edge.
- Latency: accept at edge N → mem_valid=1 with that data after edge N.
- Throughput: 1 beat/cycle while mem_ready=1.
- Back-pressure: ex_ready drops one cycle after the first unconsumed accept. The skid entry absorbs that beat.
- After flush at edge N: mem_valid=0 and ex_ready=1 after edge N.

## Configuration
- LATCH_EX_MEM_SKID_EN defined:
  - Two-entry operation as above.
  - ex_ready is registered and has no combinational dependence on mem_ready.
- Undefined:
  - No skid entry and no SKID state.
  - ex_ready = !mem_valid || mem_ready (combinational).
  - The FULL accept-only transition cannot occur; the FULL accept-and-consume transition is unchanged.
  - Reset and flush behaviour are identical in both modes.

## Test plan
- Reset: assert reset asynchronously mid-cycle with mem_valid=1 → all mem_* outputs read 0 and ex_ready=1 before the next edge.
- Streaming:
  - Stimulus: mem_ready=1; beats (1, 5, 0x0000_0011), (1, 6, 0x0000_0022), (0, 7, 0xFFFF_FFFF).
  - Response: same triples appear one cycle later, in order. The third shows mem_register_write_enable=0.
- Stall with skid (macro defined):
  - Stimulus: mem_ready=0, accept A=(1, 3, 0xA) then B=(1, 4, 0xB).
  - Response: ex_ready=0 after B. Outputs hold A. When mem_ready goes to 1, A then B are consumed, then ex_ready=1.
- Stall without skid (macro undefined):
  - Stimulus: same sequence.
  - Response: ex_ready=0 combinationally while A is held. B is accepted only in the cycle mem_ready=1.
- Flush:
  - Stimulus: in SKID state, pulse flush together with ex_valid=1.
  - Response: mem_valid=0 and mem_register_write_enable=0 next cycle. Neither held beat nor the new beat ever appears. ex_ready=1.
- Width: DATA_WIDTH=64, ADDR_WIDTH=6.
  - Stimulus: beat (1, 63, 0xDEAD_BEEF_0123_4567).
  - Response: passes bit-exact.
